// File: rtl/needs_engine_if.sv
// needs_engine_if: request/readout bundle between the menu logic and the needs core.
//
// Handshake: refill_req[i], heal_req and med_add are single-cycle request
// pulses from the master. The core answers every refill_req[i] and every
// heal_req in the following cycle with exactly one single-cycle pulse, either
// on the matching *_ack or on the matching *_nack line. med_add gets no answer.
// All readouts (need_vals, life, medicines, disease, death, tick) are
// registered in the core.
interface needs_engine_if #(
  parameter int NUM_NEEDS = 3,
  parameter int VAL_W     = 7
);
  logic [4*NUM_NEEDS-1:0]     decay_period;
  logic [NUM_NEEDS-1:0]       refill_req;
  logic                       heal_req;
  logic                       med_add;
  logic [VAL_W*NUM_NEEDS-1:0] need_vals;
  logic [VAL_W-1:0]           life;
  logic [VAL_W-1:0]           medicines;
  logic [NUM_NEEDS-1:0]       refill_ack;
  logic [NUM_NEEDS-1:0]       refill_nack;
  logic                       heal_ack;
  logic                       heal_nack;
  logic                       disease;
  logic                       death;
  logic                       tick;

  // Menu side: issues requests, reads levels and answers.
  modport master (
    output decay_period, refill_req, heal_req, med_add,
    input  need_vals, life, medicines, refill_ack, refill_nack,
           heal_ack, heal_nack, disease, death, tick
  );

  // Core side.
  modport slave (
    input  decay_period, refill_req, heal_req, med_add,
    output need_vals, life, medicines, refill_ack, refill_nack,
           heal_ack, heal_nack, disease, death, tick
  );
endinterface

// File: rtl/needs_engine.sv
// needs_engine: pet-needs core. Decays needs on a shared tick, moves life up or
// down from the need levels, serves refill/heal requests with per-need cooldown,
// and raises disease/death flags from the life level.
module needs_engine #(
  parameter int NUM_NEEDS   = 3,
  parameter int VAL_W       = 7,
  parameter int MAX_VAL     = 100,
  parameter int INIT_NEED   = 50,
  parameter int INIT_LIFE   = 100,
  parameter int TICK_DIV    = 50000000,
  parameter int LIFE_PLUS   = 70,
  parameter int LIFE_MINUS  = 30,
  parameter int DISEASE_TH  = 20,
  parameter int REFILL_STEP = 5,
  parameter int COOLDOWN    = 3,
  parameter int HEAL_STEP   = 20,
  parameter int MED_MAX     = 9
) (
  input  logic          clk,
  input  logic          btn_reset,
  needs_engine_if.slave bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int SW    = VAL_W + 2;          // signed headroom for +/- steps
  localparam int CD_W  = $clog2(COOLDOWN + 2);

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic signed [SW-1:0]  S_ZERO    = '0;
  localparam logic signed [SW-1:0]  S_ONE     = SW'(1);
  localparam logic signed [SW-1:0]  S_MAX     = SW'(MAX_VAL);
  localparam logic signed [SW-1:0]  S_REFILL  = SW'(REFILL_STEP);
  localparam logic signed [SW-1:0]  S_HEAL    = SW'(HEAL_STEP);
  localparam logic [VAL_W-1:0]      V_MAX     = VAL_W'(MAX_VAL);
  localparam logic [VAL_W-1:0]      V_PLUS    = VAL_W'(LIFE_PLUS);
  localparam logic [VAL_W-1:0]      V_MINUS   = VAL_W'(LIFE_MINUS);
  localparam logic [VAL_W-1:0]      V_DIS_TH  = VAL_W'(DISEASE_TH);
  localparam logic [VAL_W-1:0]      V_MED_MAX = VAL_W'(MED_MAX);
  localparam logic [CD_W-1:0]       CD_LOAD   = CD_W'(COOLDOWN);

  // Tick divider
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             w_tick_now;

  // Per-need state and next values
  logic [VAL_W-1:0]         r_need     [NUM_NEEDS];
  logic [VAL_W-1:0]         w_need_nxt [NUM_NEEDS];
  logic signed [SW-1:0]     w_need_sum [NUM_NEEDS];
  logic [3:0]               r_cnt      [NUM_NEEDS];
  logic [3:0]               w_cnt_nxt  [NUM_NEEDS];
  logic [4:0]               w_cnt_inc  [NUM_NEEDS];
  logic [3:0]               w_period   [NUM_NEEDS];
  logic [CD_W-1:0]          r_cd       [NUM_NEEDS];
  logic [CD_W-1:0]          w_cd_nxt   [NUM_NEEDS];
  logic [NUM_NEEDS-1:0]     w_dec;
  logic [NUM_NEEDS-1:0]     w_refill_ok;

  // Life, medicine and flags
  logic [VAL_W-1:0]         r_life;
  logic [VAL_W-1:0]         w_life_nxt;
  logic signed [SW-1:0]     w_life_sum;
  logic signed [SW-1:0]     w_delta;
  logic [VAL_W-1:0]         r_med;
  logic [VAL_W-1:0]         w_med_nxt;
  logic [VAL_W:0]           w_med_sum;
  logic                     w_heal_ok;
  logic                     w_med_add_ok;
  logic                     w_dead;
  logic                     r_disease;
  logic                     r_death;

  // Answer pulses
  logic [NUM_NEEDS-1:0]     r_refill_ack;
  logic [NUM_NEEDS-1:0]     r_refill_nack;
  logic                     r_heal_ack;
  logic                     r_heal_nack;

  // Life reaching zero freezes the core at once; the death flag follows a cycle later.
  assign w_tick_now = (r_div == DIV_LAST);
  assign w_dead     = r_death || (r_life == '0);

  // Free-running tick divider; tick pulses in the cycle after the wrap edge.
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_tick_now ? '0 : r_div + DIV_W'(1);
      r_tick <= w_tick_now;
    end
  end

  // Per-need decay, refill acceptance, cooldown and combined saturating update.
  always_comb begin
    w_dec       = '0;
    w_refill_ok = '0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      w_period[i]    = bus.decay_period[i*4 +: 4];
      w_cnt_inc[i]   = {1'b0, r_cnt[i]} + 5'd1;
      w_dec[i]       = w_tick_now && (w_period[i] != 4'd0) &&
                       (w_cnt_inc[i] >= {1'b0, w_period[i]});
      w_refill_ok[i] = bus.refill_req[i] && (r_cd[i] == '0) && !w_dead;
      w_need_sum[i]  = $signed({2'b00, r_need[i]})
                       - (w_dec[i] ? S_ONE : S_ZERO)
                       + (w_refill_ok[i] ? S_REFILL : S_ZERO);
      if (w_need_sum[i] < S_ZERO) begin
        w_need_nxt[i] = '0;
      end else if (w_need_sum[i] > S_MAX) begin
        w_need_nxt[i] = V_MAX;
      end else begin
        w_need_nxt[i] = w_need_sum[i][VAL_W-1:0];
      end
      if (!w_tick_now) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (w_dec[i]) begin
        w_cnt_nxt[i] = 4'd0;
      end else begin
        w_cnt_nxt[i] = w_cnt_inc[i][3:0];
      end
      if (w_refill_ok[i]) begin
        w_cd_nxt[i] = CD_LOAD;
      end else if (w_tick_now && (r_cd[i] != '0)) begin
        w_cd_nxt[i] = r_cd[i] - CD_W'(1);
      end else begin
        w_cd_nxt[i] = r_cd[i];
      end
    end
  end

  // Life delta from pre-tick needs, heal acceptance, medicine stock update.
  always_comb begin
    w_delta = S_ZERO;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (r_need[i] >= V_PLUS) begin
        w_delta = w_delta + S_ONE;
      end
      if (r_need[i] <= V_MINUS) begin
        w_delta = w_delta - S_ONE;
      end
    end
    w_heal_ok  = bus.heal_req && (r_med != '0) && r_disease && !w_dead;
    w_life_sum = $signed({2'b00, r_life})
                 + (w_tick_now ? w_delta : S_ZERO)
                 + (w_heal_ok ? S_HEAL : S_ZERO);
    if (w_life_sum < S_ZERO) begin
      w_life_nxt = '0;
    end else if (w_life_sum > S_MAX) begin
      w_life_nxt = V_MAX;
    end else begin
      w_life_nxt = w_life_sum[VAL_W-1:0];
    end
    w_med_add_ok = bus.med_add && !w_dead;
    w_med_sum    = {1'b0, r_med} + {VAL_W'(0), w_med_add_ok} - {VAL_W'(0), w_heal_ok};
    w_med_nxt    = (w_med_sum > {1'b0, V_MED_MAX}) ? V_MED_MAX : w_med_sum[VAL_W-1:0];
  end

  // Need, decay-counter and cooldown registers; frozen once dead.
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      for (int i = 0; i < NUM_NEEDS; i++) begin
        r_need[i] <= VAL_W'(INIT_NEED);
        r_cnt[i]  <= '0;
        r_cd[i]   <= '0;
      end
    end else if (!w_dead) begin
      for (int i = 0; i < NUM_NEEDS; i++) begin
        r_need[i] <= w_need_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
        r_cd[i]   <= w_cd_nxt[i];
      end
    end
  end

  // Life, medicine and health flags; flags follow the registered life one cycle later.
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      r_life    <= VAL_W'(INIT_LIFE);
      r_med     <= '0;
      r_disease <= 1'b0;
      r_death   <= 1'b0;
    end else begin
      if (!w_dead) begin
        r_life <= w_life_nxt;
        r_med  <= w_med_nxt;
      end
      r_disease <= (r_life <= V_DIS_TH) && !w_dead;
      r_death   <= w_dead;
    end
  end

  // One-cycle ack/nack answers to every refill and heal request.
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      r_refill_ack  <= '0;
      r_refill_nack <= '0;
      r_heal_ack    <= 1'b0;
      r_heal_nack   <= 1'b0;
    end else begin
      r_refill_ack  <= bus.refill_req & w_refill_ok;
      r_refill_nack <= bus.refill_req & ~w_refill_ok;
      r_heal_ack    <= bus.heal_req & w_heal_ok;
      r_heal_nack   <= bus.heal_req & ~w_heal_ok;
    end
  end

  for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_need_out
    assign bus.need_vals[g*VAL_W +: VAL_W] = r_need[g];
  end

  assign bus.life        = r_life;
  assign bus.medicines   = r_med;
  assign bus.refill_ack  = r_refill_ack;
  assign bus.refill_nack = r_refill_nack;
  assign bus.heal_ack    = r_heal_ack;
  assign bus.heal_nack   = r_heal_nack;
  assign bus.disease     = r_disease;
  assign bus.death       = r_death;
  assign bus.tick        = r_tick;

endmodule

// File: tb/tb_needs_engine.sv
// tb_needs_engine: directed bench for needs_engine with a fast tick (TICK_DIV=4).
module tb_needs_engine;

  localparam int NN = 3;
  localparam int VW = 7;

  typedef struct {
    int         ticks;   // cumulative ticks since reset
    logic [6:0] n0;
    logic [6:0] n1;
    logic [6:0] n2;
    logic [6:0] life;
    logic       dis;
    logic       dth;
  } vec_t;

  logic clk;
  logic btn_reset;
  int   errors;
  int   checks;

  needs_engine_if #(.NUM_NEEDS(NN), .VAL_W(VW)) bus ();

  needs_engine #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time guard
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] get_need(input int i);
    return bus.need_vals[i*VW +: VW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until tick is seen (values then already include that tick).
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick !== 1'b1 && n < 20);
    if (bus.tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got 0 required 1");
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) wait_tick();
  endtask

  task automatic apply_reset(input logic [11:0] per);
    btn_reset        = 1'b1;
    bus.refill_req   = '0;
    bus.heal_req     = 1'b0;
    bus.med_add      = 1'b0;
    bus.decay_period = per;
    repeat (2) @(posedge clk);
    #1;
    btn_reset = 1'b0;
  endtask

  vec_t vecs[9];
  int   ticks_done;
  int   acks;

  initial begin
    errors = 0;
    checks = 0;
    btn_reset        = 1'b1;
    bus.refill_req   = '0;
    bus.heal_req     = 1'b0;
    bus.med_add      = 1'b0;
    bus.decay_period = '0;

    vecs[0] = '{10, 7'd40, 7'd40, 7'd40, 7'd100, 1'b0, 1'b0};
    vecs[1] = '{20, 7'd30, 7'd30, 7'd30, 7'd100, 1'b0, 1'b0};
    vecs[2] = '{21, 7'd29, 7'd29, 7'd29, 7'd97,  1'b0, 1'b0};
    vecs[3] = '{30, 7'd20, 7'd20, 7'd20, 7'd70,  1'b0, 1'b0};
    vecs[4] = '{47, 7'd3,  7'd3,  7'd3,  7'd19,  1'b1, 1'b0};
    vecs[5] = '{50, 7'd0,  7'd0,  7'd0,  7'd10,  1'b1, 1'b0};
    vecs[6] = '{53, 7'd0,  7'd0,  7'd0,  7'd1,   1'b1, 1'b0};
    vecs[7] = '{54, 7'd0,  7'd0,  7'd0,  7'd0,   1'b0, 1'b1};
    vecs[8] = '{60, 7'd0,  7'd0,  7'd0,  7'd0,   1'b0, 1'b1};

    // ---- reset state, all periods 1 ----
    apply_reset(12'h111);
    check("rst_need0", get_need(0), 50);
    check("rst_need1", get_need(1), 50);
    check("rst_need2", get_need(2), 50);
    check("rst_life", bus.life, 100);
    check("rst_med", bus.medicines, 0);
    check("rst_disease", bus.disease, 0);
    check("rst_death", bus.death, 0);
    check("rst_tick", bus.tick, 0);
    check("rst_acks", {bus.refill_ack, bus.refill_nack, bus.heal_ack, bus.heal_nack}, 0);

    // ---- decay / life / death table ----
    ticks_done = 0;
    for (int v = 0; v < 9; v++) begin
      while (ticks_done < vecs[v].ticks) begin
        wait_tick();
        ticks_done++;
      end
      step();
      check($sformatf("v%0d_need0", v), get_need(0), vecs[v].n0);
      check($sformatf("v%0d_need1", v), get_need(1), vecs[v].n1);
      check($sformatf("v%0d_need2", v), get_need(2), vecs[v].n2);
      check($sformatf("v%0d_life", v), bus.life, vecs[v].life);
      check($sformatf("v%0d_disease", v), bus.disease, vecs[v].dis);
      check($sformatf("v%0d_death", v), bus.death, vecs[v].dth);
    end

    // ---- dead: everything rejected, stock frozen, tick alive ----
    bus.refill_req = 3'b111;
    step();
    bus.refill_req = '0;
    check("dead_refill_nack", bus.refill_nack, 3'b111);
    check("dead_refill_ack", bus.refill_ack, 3'b000);
    bus.heal_req = 1'b1;
    bus.med_add  = 1'b1;
    step();
    bus.heal_req = 1'b0;
    bus.med_add  = 1'b0;
    check("dead_heal_nack", bus.heal_nack, 1);
    check("dead_med", bus.medicines, 0);
    check("dead_need0", get_need(0), 0);
    wait_tick();
    check("dead_sticky", bus.death, 1);
    check("dead_disease", bus.disease, 0);
    check("dead_life", bus.life, 0);

    apply_reset(12'h000);
    check("rerst_need1", get_need(1), 50);
    check("rerst_life", bus.life, 100);
    check("rerst_med", bus.medicines, 0);
    step();
    check("rerst_death", bus.death, 0);

    // ---- refill up to 98, clamp at 100, cooldown of 3 ticks ----
    apply_reset(12'h001);
    wait_ticks(2);
    check("pre_need0", get_need(0), 48);
    bus.decay_period = 12'h000;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      bus.refill_req = 3'b001;
      step();
      bus.refill_req = '0;
      if (bus.refill_ack == 3'b001) acks++;
      wait_ticks(3);
    end
    check("refill_ack_count", acks, 10);
    check("need0_98", get_need(0), 98);
    bus.refill_req = 3'b001;
    step();
    check("clamp_ack", bus.refill_ack, 3'b001);
    check("clamp_need0", get_need(0), 100);
    step();
    bus.refill_req = '0;
    check("cool_nack", bus.refill_nack, 3'b001);
    check("cool_no_ack", bus.refill_ack, 3'b000);
    wait_ticks(2);
    bus.refill_req = 3'b001;
    step();
    bus.refill_req = '0;
    check("cool_2tick_nack", bus.refill_nack, 3'b001);
    wait_ticks(1);
    bus.refill_req = 3'b001;
    step();
    bus.refill_req = '0;
    check("cool_3tick_ack", bus.refill_ack, 3'b001);
    check("refill_life", bus.life, 100);

    // ---- refill coinciding with decay, multi-bit request, async reset ----
    apply_reset(12'h000);
    wait_ticks(1);
    check("co_need1_pre", get_need(1), 50);
    bus.decay_period = 12'h010;
    repeat (3) step();
    bus.refill_req = 3'b011;
    step();
    bus.refill_req = '0;
    check("co_tick", bus.tick, 1);
    check("co_need0", get_need(0), 55);
    check("co_need1", get_need(1), 54);
    check("co_ack", bus.refill_ack, 3'b011);
    check("co_nack", bus.refill_nack, 3'b000);
    #1 btn_reset = 1'b1;
    #1;
    check("arst_ack", bus.refill_ack, 3'b000);
    check("arst_need1", get_need(1), 50);

    // ---- heal / medicine ----
    apply_reset(12'h111);
    wait_ticks(48);
    check("h_life16", bus.life, 16);
    check("h_disease", bus.disease, 1);
    bus.heal_req = 1'b1;
    step();
    bus.heal_req = 1'b0;
    check("h_nack_nomed", bus.heal_nack, 1);
    check("h_life_kept", bus.life, 16);
    bus.med_add = 1'b1;
    step();
    step();
    bus.med_add = 1'b0;
    check("h_med2", bus.medicines, 2);
    wait_ticks(1);
    check("h_life13", bus.life, 13);
    bus.heal_req = 1'b1;
    step();
    bus.heal_req = 1'b0;
    check("h_ack", bus.heal_ack, 1);
    check("h_life33", bus.life, 33);
    check("h_med1", bus.medicines, 1);
    check("h_dis_lag", bus.disease, 1);
    step();
    check("h_dis_clear", bus.disease, 0);
    bus.med_add = 1'b1;
    repeat (10) step();
    bus.med_add = 1'b0;
    check("h_med_sat", bus.medicines, 9);
    wait_ticks(2);
    step();
    check("h_life18", bus.life, 18);
    check("h_dis_again", bus.disease, 1);
    bus.heal_req = 1'b1;
    bus.med_add  = 1'b1;
    step();
    bus.heal_req = 1'b0;
    bus.med_add  = 1'b0;
    check("h_both_ack", bus.heal_ack, 1);
    check("h_both_med", bus.medicines, 9);
    check("h_both_life", bus.life, 38);

    // ---- per-need periods: 3, 1, 0 ----
    apply_reset(12'h013);
    wait_ticks(20);
    check("p_need0", get_need(0), 44);
    check("p_need1", get_need(1), 30);
    check("p_need2", get_need(2), 50);
    check("p_life", bus.life, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
